// File: rtl/vga_text_display_pkg.sv
// rtl/vga_text_display_pkg.sv - shared timing, buffer geometry and colour packing
package vga_text_display_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_TOTAL = 800;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_TOTAL = 525;

  localparam int SCREEN_BUF_START = 0;
  localparam int COLS             = 80;
  localparam int ROWS             = 30;
  localparam int WORDS_PER_ROW    = 40;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb_t;

  function automatic rgb_t to_rgb(input logic [7:0] packed_colour);
    return rgb_t'(packed_colour);
  endfunction

endpackage

// File: rtl/vga_text_display_font_rom.sv
// rtl/vga_text_display_font_rom.sv - 128x16x8 glyph table, row 0 in the top byte
module font_rom (
  input  logic [6:0] code,
  input  logic [3:0] row,
  output logic [7:0] bits
);

  logic [127:0] glyph;

  always_comb begin
    glyph = '0;
    case (code)
      7'h41:   glyph = 128'h183C_6666_6666_7E66_6666_6666_6600_0000;
      7'h48:   glyph = 128'h6666_6666_6666_667E_6666_6666_6600_0000;
      7'h7F:   glyph = {128{1'b1}};
      default: glyph = '0;
    endcase
  end

  // {~row, 3'b111} is 127 - 8*row, the MSB of that row's byte
  assign bits = glyph[{~row, 3'b111} -: 8];

endmodule

// File: rtl/vga_text_display.sv
// rtl/vga_text_display.sv - 80x30 text-mode VGA scan-out with a 2-tick pixel pipeline
// and a blinking cursor overlay.
module vga_text_display
  import vga_text_display_pkg::*;
#(
  parameter int          CLK_DIV      = 2,
  parameter int          BUF_START    = SCREEN_BUF_START,
  parameter int          BLINK_FRAMES = 32,
  parameter logic [7:0]  FG           = 8'hFF,
  parameter logic [7:0]  BG           = 8'h00,
  parameter int          H_ACTIVE     = H_VIS,
  parameter int          H_FRONT      = H_FP,
  parameter int          H_PULSE      = H_SYNC,
  parameter int          H_PERIOD     = H_TOTAL,
  parameter int          V_ACTIVE     = V_VIS,
  parameter int          V_FRONT      = V_FP,
  parameter int          V_PULSE      = V_SYNC,
  parameter int          V_PERIOD     = V_TOTAL
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [15:0] RADDR_SCREEN,
  input  logic [15:0] DATA_OUT_SCREEN,
  input  logic [11:0] CURSOR_POS,
  input  logic        CURSOR_EN,
  output logic [2:0]  VGA_R,
  output logic [2:0]  VGA_G,
  output logic [1:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        FRAME_START
);

  localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST     = 10'(H_PERIOD - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_PERIOD - 1);
  localparam logic [9:0]  H_VIS_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  V_VIS_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  HS_START   = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0]  HS_END     = 10'(H_ACTIVE + H_FRONT + H_PULSE);
  localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FRONT + V_PULSE);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);
  localparam rgb_t        FG_C       = to_rgb(FG);
  localparam rgb_t        BG_C       = to_rgb(BG);

  logic [7:0]  div_cnt;
  logic        tick;
  logic [9:0]  h;
  logic [9:0]  v;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) div_cnt <= '0;
    else     div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      h <= '0;
      v <= '0;
    end else if (tick) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  // Clamping keeps blanking-time reads inside the visible buffer window
  logic [4:0] addr_row;
  logic [5:0] addr_word;

  always_comb begin
    addr_row  = (v > V_VIS_LAST) ? V_VIS_LAST[8:4] : v[8:4];
    addr_word = (h > H_VIS_LAST) ? H_VIS_LAST[9:4] : h[9:4];
  end

  assign RADDR_SCREEN = 16'(BUF_START) + 16'(addr_row) * 16'(WORDS_PER_ROW) + 16'(addr_word);

  logic [7:0]  cur_byte;
  logic [11:0] cell_idx;

  assign cur_byte = h[3] ? DATA_OUT_SCREEN[7:0] : DATA_OUT_SCREEN[15:8];
  assign cell_idx = 12'(v[9:4]) * 12'(COLS) + 12'(h[9:3]);

  logic [7:0] s1_char;
  logic [3:0] s1_row;
  logic [2:0] s1_col;
  logic       s1_vis;
  logic       s1_cur;
  logic       s1_hs;
  logic       s1_vs;
  logic       s1_first;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_char  <= '0;
      s1_row   <= '0;
      s1_col   <= '0;
      s1_vis   <= 1'b0;
      s1_cur   <= 1'b0;
      s1_hs    <= 1'b1;
      s1_vs    <= 1'b1;
      s1_first <= 1'b0;
    end else if (tick) begin
      s1_char  <= cur_byte;
      s1_row   <= v[3:0];
      s1_col   <= h[2:0];
      s1_vis   <= (h <= H_VIS_LAST) && (v <= V_VIS_LAST);
      s1_cur   <= CURSOR_EN && (cell_idx == CURSOR_POS);
      s1_hs    <= !((h >= HS_START) && (h < HS_END));
      s1_vs    <= !((v >= VS_START) && (v < VS_END));
      s1_first <= (h == 10'd0) && (v == 10'd0);
    end
  end

  logic [7:0] glyph_bits;
  logic       glyph_on;
  logic       blink_phase;
  logic       pix_on;
  rgb_t       pix;

  font_rom u_font (
    .code (s1_char[6:0]),
    .row  (s1_row),
    .bits (glyph_bits)
  );

  assign glyph_on = glyph_bits[3'd7 - s1_col];
  assign pix_on   = glyph_on ^ s1_char[7] ^ (s1_cur & blink_phase);
  assign pix      = s1_vis ? (pix_on ? FG_C : BG_C) : rgb_t'(8'h00);

  rgb_t s2_rgb;
  logic s2_first;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s2_rgb   <= rgb_t'(8'h00);
      VGA_HS   <= 1'b1;
      VGA_VS   <= 1'b1;
      s2_first <= 1'b0;
    end else if (tick) begin
      s2_rgb   <= pix;
      VGA_HS   <= s1_hs;
      VGA_VS   <= s1_vs;
      s2_first <= s1_first;
    end
  end

  assign VGA_R       = s2_rgb.r;
  assign VGA_G       = s2_rgb.g;
  assign VGA_B       = s2_rgb.b;
  assign FRAME_START = s2_first & tick;

  // The pulse that opens the first frame closes no frame, so it is not counted
  logic [15:0] blink_cnt;
  logic        frame_seen;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      frame_seen  <= 1'b0;
    end else if (FRAME_START) begin
      if (!frame_seen) begin
        frame_seen <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_text_display.sv
// tb/tb_vga_text_display.sv - bench for vga_text_display: full-timing, reduced-timing
// and divided-clock instances checked against a pixel-level model.
module tb_vga_text_display;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_bc = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] mem_a [0:2047];
  logic [15:0] mem_b [0:2047];

  logic [15:0] raddr_a, raddr_b, raddr_c, data_a, data_b, data_c;
  logic [2:0]  r_a, g_a, r_b, g_b, r_c, g_c;
  logic [1:0]  b_a, b_b, b_c;
  logic        hs_a, vs_a, fs_a, hs_b, vs_b, fs_b, hs_c, vs_c, fs_c;

  assign data_a = mem_a[raddr_a[10:0]];
  assign data_b = mem_b[raddr_b[10:0]];
  assign data_c = mem_b[raddr_c[10:0]];

  vga_text_display #(.CLK_DIV(1)) u_a (
    .CLK(clk), .RST(rst_a), .RADDR_SCREEN(raddr_a), .DATA_OUT_SCREEN(data_a),
    .CURSOR_POS(12'd2400), .CURSOR_EN(1'b1), .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .FRAME_START(fs_a));

  vga_text_display #(.CLK_DIV(1), .BUF_START(100), .BLINK_FRAMES(2), .FG(8'hE0), .BG(8'h03),
    .H_ACTIVE(32), .H_FRONT(4), .H_PULSE(8), .H_PERIOD(48),
    .V_ACTIVE(32), .V_FRONT(3), .V_PULSE(2), .V_PERIOD(40)) u_b (
    .CLK(clk), .RST(rst_bc), .RADDR_SCREEN(raddr_b), .DATA_OUT_SCREEN(data_b),
    .CURSOR_POS(12'd81), .CURSOR_EN(1'b1), .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b),
    .VGA_HS(hs_b), .VGA_VS(vs_b), .FRAME_START(fs_b));

  vga_text_display #(.CLK_DIV(2), .BUF_START(100), .BLINK_FRAMES(2), .FG(8'hE0), .BG(8'h03),
    .H_ACTIVE(32), .H_FRONT(4), .H_PULSE(8), .H_PERIOD(48),
    .V_ACTIVE(32), .V_FRONT(3), .V_PULSE(2), .V_PERIOD(40)) u_c (
    .CLK(clk), .RST(rst_bc), .RADDR_SCREEN(raddr_c), .DATA_OUT_SCREEN(data_c),
    .CURSOR_POS(12'd81), .CURSOR_EN(1'b0), .VGA_R(r_c), .VGA_G(g_c), .VGA_B(b_c),
    .VGA_HS(hs_c), .VGA_VS(vs_c), .FRAME_START(fs_c));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Glyph rows as drawn: 'A' and 'H' are two-stroke letters, 0x7F is a solid block
  function automatic logic [7:0] font_row(input logic [6:0] code, input int r);
    if (code == 7'h7F) return 8'hFF;
    if (code != 7'h41 && code != 7'h48) return 8'h00;
    if (r >= 13) return 8'h00;
    if (code == 7'h41 && r == 0) return 8'h18;
    if (code == 7'h41 && r == 1) return 8'h3C;
    if (code == 7'h41 && r == 6) return 8'h7E;
    if (code == 7'h48 && r == 7) return 8'h7E;
    return 8'h66;
  endfunction

  // n = clock edges since reset release; the pixel on the outputs is the one whose
  // linear raster index is (ticks - 2)
  function automatic void model(input int inst, input int n, input logic rst,
      output logic [7:0] rgb, output logic hs, output logic vs, output logic fs);
    int d, ha, hf, hp, ht, va, vf, vp, vt, bs, blink, cpos;
    int k, p, h, v, frame, col, row;
    logic cen, bit_on, inv;
    logic [7:0] fg, bg, ch, fr;
    logic [15:0] word;
    if (inst == 0) begin
      d = 1; ha = 640; hf = 16; hp = 96; ht = 800; va = 480; vf = 10; vp = 2; vt = 525;
      bs = 0; blink = 32; cpos = 2400; cen = 1'b1; fg = 8'hFF; bg = 8'h00;
    end else begin
      d = (inst == 1) ? 1 : 2; ha = 32; hf = 4; hp = 8; ht = 48; va = 32; vf = 3; vp = 2; vt = 40;
      bs = 100; blink = 2; cpos = 81; cen = (inst == 1); fg = 8'hE0; bg = 8'h03;
    end
    rgb = 8'h00; hs = 1'b1; vs = 1'b1; fs = 1'b0;
    k = n / d;
    if (!rst && k >= 2) begin
      p = k - 2;
      h = p % ht;
      v = (p / ht) % vt;
      frame = p / (ht * vt);
      fs = (p % (ht * vt) == 0) && (n % d == d - 1);
      hs = !(h >= ha + hf && h < ha + hf + hp);
      vs = !(v >= va + vf && v < va + vf + vp);
      if (h < ha && v < va) begin
        col = h / 8;
        row = v / 16;
        word = (inst == 0) ? mem_a[bs + row * 40 + col / 2] : mem_b[bs + row * 40 + col / 2];
        ch = (col % 2 == 0) ? word[15:8] : word[7:0];
        fr = font_row(ch[6:0], v % 16);
        bit_on = fr[7 - (h % 8)];
        inv = ch[7] ^ (cen && (row * 80 + col == cpos) && ((frame / blink) % 2 == 1));
        rgb = (bit_on ^ inv) ? fg : bg;
      end
    end
  endfunction

  int n_a = 0, n_b = 0, n_c = 0;
  always @(posedge clk) begin
    n_a <= rst_a ? 0 : n_a + 1;
    n_b <= rst_bc ? 0 : n_b + 1;
    n_c <= rst_bc ? 0 : n_c + 1;
  end

  logic [7:0] e_rgb;
  logic       e_hs, e_vs, e_fs;

  always @(negedge clk) begin
    model(0, n_a, rst_a, e_rgb, e_hs, e_vs, e_fs);
    check("a_rgb", {8'h00, r_a, g_a, b_a}, {8'h00, e_rgb});
    check("a_hs", {15'd0, hs_a}, {15'd0, e_hs});
    check("a_vs", {15'd0, vs_a}, {15'd0, e_vs});
    check("a_fs", {15'd0, fs_a}, {15'd0, e_fs});
    check("a_raddr_range", {15'd0, raddr_a <= 16'd1199}, 16'd1);
    model(1, n_b, rst_bc, e_rgb, e_hs, e_vs, e_fs);
    check("b_rgb", {8'h00, r_b, g_b, b_b}, {8'h00, e_rgb});
    check("b_hs", {15'd0, hs_b}, {15'd0, e_hs});
    check("b_vs", {15'd0, vs_b}, {15'd0, e_vs});
    check("b_fs", {15'd0, fs_b}, {15'd0, e_fs});
    check("b_raddr_range", {15'd0, raddr_b >= 16'd100 && raddr_b <= 16'd141}, 16'd1);
    model(2, n_c, rst_bc, e_rgb, e_hs, e_vs, e_fs);
    check("c_rgb", {8'h00, r_c, g_c, b_c}, {8'h00, e_rgb});
    check("c_hs", {15'd0, hs_c}, {15'd0, e_hs});
    check("c_vs", {15'd0, vs_c}, {15'd0, e_vs});
    check("c_fs", {15'd0, fs_c}, {15'd0, e_fs});
  end

  int a_hs_low = 0, b_vs_low = 0, b_fs_cnt = 0;

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem_a[i] = 16'h0000;
      mem_b[i] = 16'h0000;
    end
    mem_a[0]    = 16'h4841;
    mem_a[39]   = 16'h7F00;
    mem_a[1199] = 16'h8041;
    mem_b[100]  = 16'h4841;
    mem_b[101]  = 16'h8000;
    mem_b[140]  = 16'h4148;
    mem_b[141]  = 16'h7F41;

    repeat (3) @(negedge clk);
    #1;
    check("rst_a_rgb", {8'h00, r_a, g_a, b_a}, 16'h0000);
    check("rst_a_sync", {14'd0, hs_a, vs_a}, 16'h0003);
    check("rst_a_fs", {15'd0, fs_a}, 16'h0000);
    check("rst_a_raddr", raddr_a, 16'd0);
    check("rst_b_raddr", raddr_b, 16'd100);
    #1;
    rst_a = 1'b0;
    rst_bc = 1'b0;

    for (int m = 1; m <= 10400; m++) begin
      @(negedge clk);
      #1;
      if (m >= 2 && m <= 801 && !hs_a) a_hs_low++;
      if (m >= 2 && m <= 1921 && !vs_b) b_vs_low++;
      if (m >= 2 && m <= 1921 && fs_b) b_fs_cnt++;
      if (m == 2) begin
        check("a_first_fs", {15'd0, fs_a}, 16'd1);
        check("a_H_px0", {8'h00, r_a, g_a, b_a}, 16'h0000);
        check("b_H_px0", {8'h00, r_b, g_b, b_b}, 16'h0003);
      end
      if (m == 3) begin
        check("a_H_px1", {8'h00, r_a, g_a, b_a}, 16'h00FF);
        check("b_H_px1", {8'h00, r_b, g_b, b_b}, 16'h00E0);
      end
      if (m == 4)  check("c_fs_early", {15'd0, fs_c}, 16'd0);
      if (m == 5)  check("c_fs_tick", {15'd0, fs_c}, 16'd1);
      if (m == 12) check("a_A_px10", {8'h00, r_a, g_a, b_a}, 16'h0000);
      if (m == 13) check("a_A_px11", {8'h00, r_a, g_a, b_a}, 16'h00FF);
      if (m == 16) check("a_raddr_h16", raddr_a, 16'd1);
      if (m == 18) check("b_inv_blank", {8'h00, r_b, g_b, b_b}, 16'h00E0);
      if (m == 26) check("b_blank", {8'h00, r_b, g_b, b_b}, 16'h0003);
      if (m == 42) check("b_hblank_black", {8'h00, r_b, g_b, b_b}, 16'h0000);
      if (m == 657) check("a_hs_before", {15'd0, hs_a}, 16'd1);
      if (m == 658) check("a_hs_start", {15'd0, hs_a}, 16'd0);
      if (m == 702) check("a_raddr_clamp", raddr_a, 16'd39);
      if (m == 754) check("a_hs_after", {15'd0, hs_a}, 16'd1);
      if (m == 778)  check("b_cursor_f0", {8'h00, r_b, g_b, b_b}, 16'h0003);
      if (m == 1682) check("b_vs_start", {15'd0, vs_b}, 16'd0);
      if (m == 1900) begin
        #1;
        rst_a = 1'b1;
        #1;
        check("a_midrst_rgb", {8'h00, r_a, g_a, b_a}, 16'h0000);
        check("a_midrst_sync", {14'd0, hs_a, vs_a}, 16'h0003);
        check("a_midrst_raddr", raddr_a, 16'd0);
      end
      if (m == 1903) begin
        #1;
        rst_a = 1'b0;
      end
      if (m == 1905) check("a_restart_fs", {15'd0, fs_a}, 16'd1);
      if (m == 1906) check("a_restart_px1", {8'h00, r_a, g_a, b_a}, 16'h00FF);
      if (m == 1922) check("b_fs_frame1", {15'd0, fs_b}, 16'd1);
      if (m == 2698)  check("b_cursor_f1", {8'h00, r_b, g_b, b_b}, 16'h0003);
      if (m == 4618)  check("b_cursor_f2", {8'h00, r_b, g_b, b_b}, 16'h00E0);
      if (m == 6538)  check("b_cursor_f3", {8'h00, r_b, g_b, b_b}, 16'h00E0);
      if (m == 8458)  check("b_cursor_f4", {8'h00, r_b, g_b, b_b}, 16'h0003);
      if (m == 9237)  check("c_nocursor_f2", {8'h00, r_c, g_c, b_c}, 16'h0003);
      if (m == 10378) check("b_cursor_f5", {8'h00, r_b, g_b, b_b}, 16'h0003);
    end

    check("a_hs_low_ticks", 16'(a_hs_low), 16'd96);
    check("b_vs_low_ticks", 16'(b_vs_low), 16'd96);
    check("b_fs_per_frame", 16'(b_fs_cnt), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
